hs_ram_arbiter: RTL and testbench
=================================

Name: hs_ram_arbiter

Overview:
- Shares the game core's single-port work RAM between the CPU and the hiscore save/restore engine.
- In normal play the CPU owns the RAM port. When the hiscore engine requests access and the CPU is paused, the block waits a settle interval, grants the port to the hiscore engine, then returns it to the CPU.
- It also holds the CPU paused for the whole transfer and flags any CPU write attempted while the CPU does not own the port.
- Sits between the game core RAM port, the pause block and the hiscore block.

Parameters:
- AW, 11, RAM address width (2 KB work RAM).
- SETTLE_CYCLES, 4, cycles CPU must stay paused before grant; legal range 1..15.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_paused  in  1  level from pause block: CPU is halted
- cpu_addr  in  AW  CPU RAM address
- cpu_we  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  RAM read data to CPU (direct pass of ram_rdata)
- cpu_hold  out  1  extra pause to core; OR'd into the core's pause input
- hs_access  in  1  hiscore engine requests port (level)
- hs_write  in  1  hiscore write strobe
- hs_address  in  AW  hiscore address
- hs_data_in  in  8  hiscore write data
- hs_data_out  out  8  registered read data to hiscore
- hs_grant  out  1  port owned by hiscore engine
- hs_rvalid  out  1  hs_data_out updated this cycle
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, synchronous, 1-cycle latency
- collision  out  1  sticky: CPU write blocked while CPU did not own the port

Behaviour:
- Reset values: state IDLE; cpu_hold=0, hs_grant=0, hs_rvalid=0, hs_data_out=8'h00, collision=0, settle counter=0. The RAM mux selects the CPU during reset.
- FSM state IDLE:
  - RAM port = CPU (ram_we=cpu_we).
  - hs_access & cpu_paused → SETTLE; counter loads SETTLE_CYCLES-1; cpu_hold=1 from the next cycle.
- FSM state SETTLE:
  - RAM port = CPU address, ram_we forced 0.
  - If hs_access falls → IDLE, cpu_hold released.
  - If cpu_paused falls, the counter reloads; cpu_hold stays asserted.
  - Counter==0 & cpu_paused → GRANT.
  - SETTLE_CYCLES=1 gives exactly one SETTLE cycle.
- FSM state GRANT:
  - hs_grant=1; RAM port = hs_address/hs_write/hs_data_in, combinationally muxed.
  - Reads: address presented in cycle N; ram_rdata valid in N+1; hs_data_out registered at the end of N+1; hs_rvalid=1 in N+2 for one cycle per read cycle.
  - hs_rvalid is not raised for write cycles.
  - hs_access low → RELEASE.
- FSM state RELEASE (1 cycle):
  - ram_we forced 0, mux back to CPU, hs_grant=0, cpu_hold=1.
  - Always → IDLE; cpu_hold=0 in IDLE.
- cpu_hold is high in SETTLE, GRANT and RELEASE, so the CPU stays stopped even if the pause block releases mid-transfer.
- hs_write asserted outside GRANT is ignored; no RAM write occurs.
- collision is set on any cycle with cpu_we=1 while state≠IDLE; it clears only on reset.
- hs_access rising during RELEASE is not serviced until IDLE, then re-arbitrated normally.
- Reset asserted mid-GRANT: grant drops asynchronously and the mux returns to the CPU immediately. No partial write is issued after reset assertion.
- An in-flight read pipeline is discarded on leaving GRANT: hs_rvalid is forced 0 in RELEASE and IDLE.

Decomposition:
- Shared package hs_arb_pkg holds:
  - the state enum (IDLE, SETTLE, GRANT, RELEASE);
  - localparam SETTLE_W=4;
  - a port-select constant pair SEL_CPU/SEL_HS.
- One natural sub-module: hs_ram_mux, the combinational address/data/we selector driven by the FSM select and we-gate. The FSM, counter and read pipeline stay in the top.

Test Plan:
1. Reset, then CPU write: cpu_we=1, addr 0x123, data 0x5A with hs_access=0 → ram_we=1, ram_addr=0x123, ram_wdata=0x5A; hs_grant=0, collision=0.
2. Paused grant: cpu_paused=1, hs_access=1 (SETTLE_CYCLES=4) → cpu_hold=1 next cycle; hs_grant=1 exactly 4 cycles after entering SETTLE.
3. Hiscore read: in GRANT, hs_address=0x3E0 with the RAM model holding 0x77 → hs_rvalid=1 and hs_data_out=0x77 two cycles after the address.
4. Hiscore write then release: hs_write=1, addr 0x3E1, data 0x09, then hs_access=0 → RAM[0x3E1]=0x09, one RELEASE cycle with ram_we=0, IDLE next with cpu_hold=0.
5. Settle abort: cpu_paused drops in SETTLE → counter reloads, no grant; pause restored → grant after SETTLE_CYCLES more cycles. hs_access dropping in SETTLE → IDLE, hs_grant never asserted.
6. Collision and async reset: cpu_we=1 during GRANT → RAM not written by CPU, collision=1 sticky. Assert reset mid-GRANT → hs_grant=0 and collision=0 without a clock edge.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// rtl/hs_arb_pkg.sv - shared types and constants for the hiscore RAM arbiter
package hs_arb_pkg;

    // Ownership phases of the shared work RAM port
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Width of the settle down-counter; SETTLE_CYCLES must fit (1..15)
    localparam int SETTLE_W = 4;

    // RAM port owner select
    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_HS  = 1'b1;

endpackage

// File: rtl/hs_ram_mux.sv
// rtl/hs_ram_mux.sv - combinational RAM port selector between CPU and hiscore engine
module hs_ram_mux
    import hs_arb_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic          sel,
    input  logic          we_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_wdata,
    input  logic [AW-1:0] hs_address,
    input  logic          hs_write,
    input  logic [7:0]    hs_data_in,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata
);

    // Route the selected owner to the RAM; we_en gates writes during hand-over phases
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        if (sel == SEL_HS) begin
            ram_addr  = hs_address;
            ram_wdata = hs_data_in;
            ram_we    = we_en & hs_write;
        end else begin
            ram_we    = we_en & cpu_we;
        end
    end

endmodule

// File: rtl/hs_ram_arbiter.sv
// rtl/hs_ram_arbiter.sv - work RAM arbiter between game CPU and hiscore save/restore engine
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int AW            = 11,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_paused,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_hold,
    input  logic          hs_access,
    input  logic          hs_write,
    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_data_in,
    output logic [7:0]    hs_data_out,
    output logic          hs_grant,
    output logic          hs_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic          collision
);

    // Counter reload: the grant comes after SETTLE_CYCLES consecutive paused cycles
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] settle_cnt_next;
    logic                mux_sel;
    logic                mux_we_en;
    logic                rd_pend;

    // Next-state, settle counter and RAM port ownership
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        mux_sel         = SEL_CPU;
        mux_we_en       = 1'b0;
        case (state)
            IDLE: begin
                mux_we_en = 1'b1;
                if (hs_access && cpu_paused) begin
                    state_next      = SETTLE;
                    settle_cnt_next = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (!hs_access) begin
                    state_next = IDLE;
                end else if (!cpu_paused) begin
                    settle_cnt_next = SETTLE_LOAD;
                end else if (settle_cnt == '0) begin
                    state_next = GRANT;
                end else begin
                    settle_cnt_next = settle_cnt - 1'b1;
                end
            end
            GRANT: begin
                mux_sel   = SEL_HS;
                mux_we_en = 1'b1;
                if (!hs_access) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter, read pipeline and sticky collision flag
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            rd_pend     <= 1'b0;
            hs_rvalid   <= 1'b0;
            hs_data_out <= 8'h00;
            collision   <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            rd_pend    <= (state == GRANT) && !hs_write;
            // Only deliver read data that will land while the port is still granted
            if (rd_pend && (state == GRANT) && (state_next == GRANT)) begin
                hs_data_out <= ram_rdata;
                hs_rvalid   <= 1'b1;
            end else begin
                hs_rvalid   <= 1'b0;
            end
            if (cpu_we && (state != IDLE)) begin
                collision <= 1'b1;
            end
        end
    end

    assign hs_grant  = (state == GRANT);
    assign cpu_hold  = (state != IDLE);
    assign cpu_rdata = ram_rdata;

    hs_ram_mux #(
        .AW(AW)
    ) u_mux (
        .sel        (mux_sel),
        .we_en      (mux_we_en),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .hs_address (hs_address),
        .hs_write   (hs_write),
        .hs_data_in (hs_data_in),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata)
    );

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb/tb_hs_ram_arbiter.sv - self-checking bench for hs_ram_arbiter
module tb_hs_ram_arbiter;

    localparam int AW = 11;
    localparam int SC = 4;
    localparam int M_IDLE    = 0;
    localparam int M_SETTLE  = 1;
    localparam int M_GRANT   = 2;
    localparam int M_RELEASE = 3;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_paused = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_we = 1'b0;
    logic [7:0]    cpu_wdata = 8'h00;
    logic [7:0]    cpu_rdata;
    logic          cpu_hold;
    logic          hs_access = 1'b0;
    logic          hs_write = 1'b0;
    logic [AW-1:0] hs_address = '0;
    logic [7:0]    hs_data_in = 8'h00;
    logic [7:0]    hs_data_out;
    logic          hs_grant;
    logic          hs_rvalid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = 8'h00;
    logic          collision;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem    [0:(1<<AW)-1];
    logic [7:0] shadow [0:(1<<AW)-1];

    int         m_ph = M_IDLE;
    int         m_nph = M_IDLE;
    int         m_run = 0;
    logic       m_coll = 1'b0;
    logic       rd1_v = 1'b0;
    logic [7:0] rd1_d = 8'h00;
    logic       exp_rv = 1'b0;
    logic [7:0] exp_dout = 8'h00;
    logic       cmp_g;

    hs_ram_arbiter #(.AW(AW), .SETTLE_CYCLES(SC)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .cpu_paused  (cpu_paused),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_hold    (cpu_hold),
        .hs_access   (hs_access),
        .hs_write    (hs_write),
        .hs_address  (hs_address),
        .hs_data_in  (hs_data_in),
        .hs_data_out (hs_data_out),
        .hs_grant    (hs_grant),
        .hs_rvalid   (hs_rvalid),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .collision   (collision)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM, read-before-write, one-cycle latency
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference model: ownership phase, paused-run count, shadow memory, read delivery
    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_ph     = M_IDLE;
            m_run    = 0;
            m_coll   = 1'b0;
            rd1_v    = 1'b0;
            exp_rv   = 1'b0;
            exp_dout = 8'h00;
        end else begin
            m_nph = m_ph;
            case (m_ph)
                M_IDLE:   if (hs_access && cpu_paused) begin m_nph = M_SETTLE; m_run = 0; end
                M_SETTLE: begin
                    if (!hs_access) m_nph = M_IDLE;
                    else if (!cpu_paused) m_run = 0;
                    else begin
                        m_run++;
                        if (m_run >= SC) m_nph = M_GRANT;
                    end
                end
                M_GRANT:  if (!hs_access) m_nph = M_RELEASE;
                default:  m_nph = M_IDLE;
            endcase
            exp_rv = rd1_v && (m_ph == M_GRANT) && (m_nph == M_GRANT);
            if (exp_rv) exp_dout = rd1_d;
            rd1_v = (m_ph == M_GRANT) && !hs_write;
            rd1_d = shadow[hs_address];
            if (m_ph == M_IDLE && cpu_we) shadow[cpu_addr] = cpu_wdata;
            else if (m_ph == M_GRANT && hs_write) shadow[hs_address] = hs_data_in;
            if (cpu_we && m_ph != M_IDLE) m_coll = 1'b1;
            m_ph = m_nph;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk_sys) begin
        if (!reset) begin
            cmp_g = (m_ph == M_GRANT);
            chk("hs_grant",    16'(hs_grant),    16'(cmp_g));
            chk("cpu_hold",    16'(cpu_hold),    16'(m_ph != M_IDLE));
            chk("ram_addr",    16'(ram_addr),    16'(cmp_g ? hs_address : cpu_addr));
            chk("ram_we",      16'(ram_we),      16'((m_ph == M_IDLE) ? cpu_we : (cmp_g ? hs_write : 1'b0)));
            chk("ram_wdata",   16'(ram_wdata),   16'(cmp_g ? hs_data_in : cpu_wdata));
            chk("collision",   16'(collision),   16'(m_coll));
            chk("hs_rvalid",   16'(hs_rvalid),   16'(exp_rv));
            chk("hs_data_out", 16'(hs_data_out), 16'(exp_dout));
            chk("cpu_rdata",   16'(cpu_rdata),   16'(ram_rdata));
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        mem[11'h3E0]    = 8'h77;
        shadow[11'h3E0] = 8'h77;

        // Reset values
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_cpu_hold",    16'(cpu_hold),    16'h0);
        chk("rst_hs_grant",    16'(hs_grant),    16'h0);
        chk("rst_hs_rvalid",   16'(hs_rvalid),   16'h0);
        chk("rst_hs_data_out", 16'(hs_data_out), 16'h00);
        chk("rst_collision",   16'(collision),   16'h0);
        reset = 1'b0;

        // CPU write in normal play
        cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 8'h5A;
        #2;
        chk("t1_ram_we",    16'(ram_we),    16'h1);
        chk("t1_ram_addr",  16'(ram_addr),  16'h123);
        chk("t1_ram_wdata", 16'(ram_wdata), 16'h5A);
        chk("t1_hs_grant",  16'(hs_grant),  16'h0);
        tick();
        cpu_we = 1'b0;
        chk("t1_mem", 16'(mem[11'h123]), 16'h5A);
        chk("t1_collision", 16'(collision), 16'h0);

        // Paused grant: SC SETTLE cycles then GRANT
        cpu_paused = 1'b1; hs_access = 1'b1;
        tick();
        chk("t2_hold_settle", 16'(cpu_hold), 16'h1);
        chk("t2_grant_s0",    16'(hs_grant), 16'h0);
        for (int k = 1; k < SC; k++) begin
            tick();
            chk("t2_grant_early", 16'(hs_grant), 16'h0);
        end
        tick();
        chk("t2_grant", 16'(hs_grant), 16'h1);

        // Hiscore read of 0x3E0
        hs_write = 1'b0; hs_address = 11'h3E0;
        tick();
        hs_address = 11'h3E5;
        tick();
        chk("t3_rvalid", 16'(hs_rvalid),   16'h1);
        chk("t3_data",   16'(hs_data_out), 16'h77);

        // Hiscore write then release
        hs_address = 11'h3E1; hs_write = 1'b1; hs_data_in = 8'h09;
        tick();
        hs_write = 1'b0; hs_access = 1'b0;
        tick();
        #2;
        chk("t4_rel_we",    16'(ram_we),   16'h0);
        chk("t4_rel_grant", 16'(hs_grant), 16'h0);
        chk("t4_rel_hold",  16'(cpu_hold), 16'h1);
        chk("t4_mem",       16'(mem[11'h3E1]), 16'h09);
        tick();
        chk("t4_idle_hold", 16'(cpu_hold), 16'h0);

        // Settle abort by pause drop, then grant after SC more paused cycles
        cpu_paused = 1'b1; hs_access = 1'b1;
        tick();
        tick();
        cpu_paused = 1'b0;
        tick();
        chk("t5_hold_reload", 16'(cpu_hold), 16'h1);
        chk("t5_no_grant",    16'(hs_grant), 16'h0);
        cpu_paused = 1'b1;
        for (int k = 1; k < SC; k++) begin
            tick();
            chk("t5_grant_early", 16'(hs_grant), 16'h0);
        end
        tick();
        chk("t5_grant", 16'(hs_grant), 16'h1);

        // CPU write during GRANT is blocked and flagged
        cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'hEE;
        hs_write = 1'b0; hs_address = 11'h020;
        #2;
        chk("t6_ram_we", 16'(ram_we), 16'h0);
        tick();
        cpu_we = 1'b0;
        chk("t6_collision", 16'(collision), 16'h1);
        chk("t6_mem_kept",  16'(mem[11'h010]), 16'h73);
        tick();
        chk("t6_sticky", 16'(collision), 16'h1);

        // Asynchronous reset mid-GRANT
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_grant", 16'(hs_grant),  16'h0);
        chk("t6_rst_coll",  16'(collision), 16'h0);
        chk("t6_rst_hold",  16'(cpu_hold),  16'h0);
        tick();
        reset = 1'b0;

        // hs_access drop in SETTLE returns to IDLE without grant
        tick();
        chk("t5b_hold", 16'(cpu_hold), 16'h1);
        hs_access = 1'b0;
        tick();
        chk("t5b_hold_idle", 16'(cpu_hold), 16'h0);
        chk("t5b_no_grant",  16'(hs_grant), 16'h0);
        cpu_paused = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 9) == 0) hs_access = ~hs_access;
            if ($urandom_range(0, 7) == 0) cpu_paused = ~cpu_paused;
            cpu_we     = ($urandom_range(0, 5) == 0);
            cpu_addr   = 11'($urandom_range(0, 31));
            cpu_wdata  = 8'($urandom);
            hs_write   = ($urandom_range(0, 2) == 0);
            hs_address = 11'($urandom_range(0, 31));
            hs_data_in = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
